// File: rtl/uart_tx_scheduler.sv
// Four-requester round-robin scheduler feeding a byte-wide UART transmitter.
// Each granted word is optionally preceded by a tag byte; a per-byte watchdog aborts stalled frames.
module uart_tx_scheduler #(
  parameter int WordLength    = 8,
  parameter int TagEn         = 1,
  parameter int TimeoutCycles = 200000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [3:0]                req_i,
  input  logic [4*WordLength-1:0]   data_i,
  output logic [3:0]                ack_o,
  output logic [WordLength-1:0]     tx_din_o,
  output logic                      tx_start_o,
  input  logic                      tx_done_tick_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                done_id_o,
  output logic                      err_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_TAG  = 3'd1,
    WAIT_TAG   = 3'd2,
    START_DATA = 3'd3,
    WAIT_DATA  = 3'd4
  } state_t;

  localparam logic [19:0] WdogLast = 20'(TimeoutCycles - 1);

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              grant_q, grant_d;
  logic [WordLength-1:0]   word_q, word_d;
  logic [WordLength-1:0]   din_q, din_d;
  logic [19:0]             wdog_q, wdog_d;
  logic [3:0]              ack_q, ack_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [1:0]              done_id_q, done_id_d;

  logic                    gnt_found;
  logic [1:0]              gnt_idx;
  logic [1:0]              gnt_cand;
  logic [WordLength-1:0]   gnt_word;

  function automatic logic [WordLength-1:0] tag_word(input logic [1:0] idx);
    logic [7:0] t;
    t = 8'hA0 + {6'd0, idx};
    return WordLength'(t);
  endfunction

  // Round-robin search starting at the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    gnt_cand  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      gnt_cand = ptr_q + 2'(i);
      if (!gnt_found && req_i[gnt_cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_cand;
      end
    end
    gnt_word = data_i[gnt_idx*WordLength +: WordLength];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      grant_q   <= 2'd0;
      word_q    <= '0;
      din_q     <= '0;
      wdog_q    <= 20'd0;
      ack_q     <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      word_q    <= word_d;
      din_q     <= din_d;
      wdog_q    <= wdog_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      done_id_q <= done_id_d;
    end
  end

  // A done tick is tested before the watchdog, so a coincident tick completes the byte.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    word_d    = word_q;
    din_d     = din_q;
    wdog_d    = wdog_q;
    ack_d     = 4'd0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          grant_d = gnt_idx;
          word_d  = gnt_word;
          ack_d   = 4'(4'b0001 << gnt_idx);
          if (TagEn != 0) begin
            state_d = START_TAG;
            din_d   = tag_word(gnt_idx);
          end else begin
            state_d = START_DATA;
            din_d   = gnt_word;
          end
        end
      end
      START_TAG: begin
        state_d = WAIT_TAG;
        wdog_d  = 20'd0;
      end
      WAIT_TAG: begin
        if (tx_done_tick_i) begin
          state_d = START_DATA;
          din_d   = word_q;
        end else if (wdog_q == WdogLast) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          done_id_d = grant_q;
          ptr_d     = grant_q + 2'd1;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
      START_DATA: begin
        state_d = WAIT_DATA;
        wdog_d  = 20'd0;
      end
      WAIT_DATA: begin
        if (tx_done_tick_i) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          done_id_d = grant_q;
          ptr_d     = grant_q + 2'd1;
        end else if (wdog_q == WdogLast) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          done_id_d = grant_q;
          ptr_d     = grant_q + 2'd1;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack_o      = ack_q;
  assign tx_din_o   = din_q;
  assign tx_start_o = (state_q == START_TAG) || (state_q == START_DATA);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a tagged instance with a short watchdog
// driven from a vector table, and an untagged instance for the data-only path.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic        tick;
  logic [3:0]  ack_o;
  logic [7:0]  tx_din_o;
  logic        tx_start_o, busy_o, done_o, err_o;
  logic [1:0]  done_id_o;

  logic [3:0]  req1;
  logic [31:0] data1;
  logic        tick1;
  logic [3:0]  ack1;
  logic [7:0]  din1;
  logic        start1, busy1, done1, err1;
  logic [1:0]  did1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.WordLength(8), .TagEn(1), .TimeoutCycles(10)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .tx_din_o(tx_din_o), .tx_start_o(tx_start_o), .tx_done_tick_i(tick),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o), .err_o(err_o)
  );

  uart_tx_scheduler #(.WordLength(8), .TagEn(0)) u_notag (
    .clk_i(clk), .rst_i(rst_i), .req_i(req1), .data_i(data1), .ack_o(ack1),
    .tx_din_o(din1), .tx_start_o(start1), .tx_done_tick_i(tick1),
    .busy_o(busy1), .done_o(done1), .done_id_o(did1), .err_o(err1)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          wt;
    int          wd;
    logic [1:0]  g;
    logic [7:0]  w;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full tagged transfer: grant, tag byte, data byte, completion.
  task automatic xfer(input logic [3:0] req, input logic [31:0] data, input int wt,
                      input int wd, input logic [1:0] g, input logic [7:0] w);
    logic [7:0] tag;
    tag    = 8'hA0 + {6'd0, g};
    req_i  = req;
    data_i = data;
    step();
    data_i = 32'hDEAD_BEEF;
    chk("ack", ack_o, 32'(4'b0001 << g));
    chk("start_tag", tx_start_o, 1);
    chk("din_tag", tx_din_o, tag);
    chk("busy_grant", busy_o, 1);
    chk("done_pulse_low", done_o, 0);
    step();
    chk("ack_one_cycle", ack_o, 0);
    chk("start_tag_low", tx_start_o, 0);
    chk("din_tag_wait", tx_din_o, tag);
    for (int k = 0; k < wt; k++) begin
      step();
      chk("din_tag_hold", tx_din_o, tag);
      chk("start_low_wtag", tx_start_o, 0);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("start_data", tx_start_o, 1);
    chk("din_data", tx_din_o, w);
    step();
    chk("start_data_low", tx_start_o, 0);
    chk("din_data_wait", tx_din_o, w);
    for (int k = 0; k < wd; k++) begin
      step();
      chk("din_data_hold", tx_din_o, w);
      chk("busy_wdata", busy_o, 1);
    end
    tick = 1'b1;
    step();
    tick  = 1'b0;
    req_i = 4'd0;
    chk("done", done_o, 1);
    chk("done_id", done_id_o, g);
    chk("err_on_done", err_o, 0);
    chk("busy_idle", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b1111, 32'h4433_2211, 0, 0, 2'd0, 8'h11};
    vecs[1] = '{4'b1111, 32'h4433_2211, 1, 2, 2'd1, 8'h22};
    vecs[2] = '{4'b1111, 32'h4433_2211, 3, 0, 2'd2, 8'h33};
    vecs[3] = '{4'b1111, 32'h4433_2211, 0, 5, 2'd3, 8'h44};
    vecs[4] = '{4'b1111, 32'h4433_2211, 9, 1, 2'd0, 8'h11};
    vecs[5] = '{4'b0100, 32'hFF5A_EE00, 2, 2, 2'd2, 8'h5A};
    vecs[6] = '{4'b0011, 32'h0000_B7C8, 0, 1, 2'd0, 8'hC8};
    vecs[7] = '{4'b1001, 32'h9D00_0077, 1, 9, 2'd3, 8'h9D};
    vecs[8] = '{4'b0110, 32'h00E1_3C00, 4, 0, 2'd1, 8'h3C};

    rst_i = 1'b0; req_i = 4'd0; data_i = 32'd0; tick = 1'b0;
    req1 = 4'd0; data1 = 32'd0; tick1 = 1'b0;
    step();
    step();
    chk("rst_ack", ack_o, 0);
    chk("rst_start", tx_start_o, 0);
    chk("rst_din", tx_din_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_done_id", done_id_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy_notag", busy1, 0);
    rst_i = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      xfer(vecs[i].req, vecs[i].data, vecs[i].wt, vecs[i].wd, vecs[i].g, vecs[i].w);

    // Watchdog abort in WAIT_TAG: pointer is 2, so requester 0 wins.
    req_i = 4'b0001; data_i = 32'h0000_0042;
    step();
    req_i = 4'd0;
    chk("to_ack", ack_o, 4'b0001);
    step();
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("to_busy", busy_o, 1);
      chk("to_err_early", err_o, 0);
    end
    step();
    chk("to_err", err_o, 1);
    chk("to_done_low", done_o, 0);
    chk("to_done_id", done_id_o, 0);
    chk("to_idle", busy_o, 0);
    step();
    chk("to_err_pulse", err_o, 0);
    xfer(4'b1111, 32'h4433_2211, 0, 0, 2'd1, 8'h22);

    // Tick ignored in START_TAG, then reset during WAIT_DATA.
    req_i = 4'b0100; data_i = 32'h0081_0000;
    step();
    req_i = 4'd0;
    chk("rs_ack", ack_o, 4'b0100);
    chk("rs_din_tag", tx_din_o, 8'hA2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ign_tick_start", tx_start_o, 0);
    chk("ign_tick_din", tx_din_o, 8'hA2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("rs_start_data", tx_start_o, 1);
    chk("rs_din_data", tx_din_o, 8'h81);
    step();
    chk("rs_busy_wdata", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_ack", ack_o, 0);
    chk("mid_rst_start", tx_start_o, 0);
    chk("mid_rst_din", tx_din_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_done_id", done_id_o, 0);
    chk("mid_rst_err", err_o, 0);
    step();
    chk("mid_rst_hold_busy", busy_o, 0);
    rst_i = 1'b1;
    xfer(4'b1010, 32'h7700_6600, 1, 1, 2'd1, 8'h66);

    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("idle_tick_busy", busy_o, 0);
    chk("idle_tick_done", done_o, 0);
    chk("idle_tick_ack", ack_o, 0);

    // Untagged instance: one start pulse carrying the data word.
    req1 = 4'b0001; data1 = 32'h0000_00C3;
    step();
    req1 = 4'd0;
    chk("nt_ack", ack1, 4'b0001);
    chk("nt_start", start1, 1);
    chk("nt_din", din1, 8'hC3);
    step();
    chk("nt_start_low", start1, 0);
    chk("nt_busy", busy1, 1);
    chk("nt_din_hold", din1, 8'hC3);
    tick1 = 1'b1;
    step();
    tick1 = 1'b0;
    chk("nt_done", done1, 1);
    chk("nt_done_id", did1, 0);
    chk("nt_start_after", start1, 0);
    chk("nt_idle", busy1, 0);
    chk("nt_err", err1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter WordLength, default 8, width of each transmitted word.
REQ-002 Parameter TagEn, default 1: 1 sends a tag byte before each data word; 0 sends the data word only.
REQ-003 Parameter TimeoutCycles, default 200000, is the per-byte watchdog limit in clk_i cycles; legal range 2 to 2^20-1.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  4  per-requester transmit request, level, held until ack.
REQ-007 data_i  input  4*WordLength  requester k word on bits [k*WordLength +: WordLength].
REQ-008 ack_o  output  4  one-cycle pulse: requester k word captured.
REQ-009 tx_din_o  output  WordLength  byte to the UART transmitter.
REQ-010 tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_done_tick_i  input  1  one-cycle pulse from the UART transmitter at end of frame.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse: transfer completed.
REQ-014 done_id_o  output  2  requester index of the last completed or aborted transfer.
REQ-015 err_o  output  1  one-cycle pulse: watchdog abort.

Function
REQ-016 The FSM SHALL have states IDLE, START_TAG, WAIT_TAG, START_DATA, WAIT_DATA.
REQ-017 In IDLE with any req_i bit high at cycle N, the FSM SHALL grant per round-robin, register the granted index and its data_i word, and at N+1 assert ack_o[grant] for exactly one cycle.
REQ-018 Round-robin: search starts at pointer p; after each completed or aborted transfer, p = (grant+1) mod 4; p = 0 after reset.
REQ-019 At N+1 the FSM SHALL be in START_TAG if TagEn=1, else in START_DATA.
REQ-020 tx_start_o SHALL be high exactly during each cycle spent in START_TAG or START_DATA (one cycle each); the next cycle enters WAIT_TAG or WAIT_DATA respectively.
REQ-021 Tag byte = 8'hA0 + grant index; tx_din_o SHALL hold the tag from START_TAG through WAIT_TAG and the captured word from START_DATA through WAIT_DATA.
REQ-022 WAIT_TAG with tx_done_tick_i -> START_DATA; WAIT_DATA with tx_done_tick_i -> IDLE, with done_o pulsed and done_id_o = grant in that transition cycle.
REQ-023 tx_done_tick_i SHALL be ignored in IDLE, START_TAG and START_DATA.
REQ-024 A 20-bit watchdog SHALL clear on entry to each WAIT state and increment each cycle in it; reaching TimeoutCycles without tx_done_tick_i -> IDLE, pulse err_o, done_id_o = grant, done_o stays low.
REQ-025 If tx_done_tick_i and the timeout coincide, done SHALL win: no err_o.
REQ-026 req_i changes after capture SHALL not affect the transfer in progress; req_i still high after ack SHALL be treated as a new request at the next IDLE.
REQ-027 A request dropped before it is sampled in IDLE SHALL not be served; data_i is sampled only in the grant cycle.
REQ-028 Minimum IDLE dwell between transfers SHALL be one cycle.

Reset
REQ-029 rst_i low SHALL immediately force IDLE, with p = 0, watchdog = 0, ack_o = 0, tx_start_o = 0, tx_din_o = 0, busy_o = 0, done_o = 0, done_id_o = 0, err_o = 0.
REQ-030 Reset asserted mid-transfer SHALL abandon it without done_o or err_o; the first grant after release SHALL use p = 0.

Verification
REQ-031 TagEn=1, req_i=4'b0100, data_i[23:16]=8'h5A -> ack_o=4'b0100 next cycle; tx_din_o=8'hA2 with tx_start_o; after done tick, tx_din_o=8'h5A with tx_start_o; after done tick, done_o=1, done_id_o=2.
REQ-032 req_i=4'b1111 held for four transfers from reset -> grants in order 0,1,2,3, then 0 again.
REQ-033 TagEn=0, req_i=4'b0001, data 8'hC3 -> a single tx_start_o with tx_din_o=8'hC3; no tag byte.
REQ-034 TimeoutCycles=10, no tx_done_tick_i -> err_o after 10 cycles in WAIT_TAG, done_id_o = grant, FSM in IDLE, p advanced.
REQ-035 Done tick and timeout in the same cycle -> done path taken, err_o=0.
REQ-036 rst_i low during WAIT_DATA -> all outputs 0 immediately; after release with req_i=4'b1010, grant is 1.
